// File: rtl/sdram_init_ctrl_if.sv
// SDRAM init sequencer bus: start/done handshake, SDRAM command pins and refresh req/ack.
// The controller side takes the master modport; the board-memory controller or bench takes slave.
interface sdram_init_ctrl_if #(
  parameter int unsigned ADDR_W = 12,
  parameter int unsigned BA_W   = 2
);
  logic              run_i;
  logic              done_o;
  logic              busy_o;
  logic              cke_o;
  logic [3:0]        cmd_o;
  logic [ADDR_W-1:0] a_o;
  logic [BA_W-1:0]   bs_o;
  logic              ref_req_o;
  logic              ref_ack_i;

  modport master (
    input  run_i, ref_ack_i,
    output done_o, busy_o, cke_o, cmd_o, a_o, bs_o, ref_req_o
  );

  modport slave (
    output run_i, ref_ack_i,
    input  done_o, busy_o, cke_o, cmd_o, a_o, bs_o, ref_req_o
  );
endinterface

// File: rtl/sdram_init_ctrl.sv
// SDR SDRAM power-up sequencer with post-init auto-refresh request timer.
// Optional extended mode register load is enabled by defining SDRAM_INIT_EMRS_EN.
module sdram_init_ctrl #(
  parameter int unsigned ADDR_W          = 12,
  parameter int unsigned BA_W            = 2,
  parameter int unsigned PAUSE_CYCLES    = 33334,
  parameter int unsigned T_RP            = 3,
  parameter int unsigned T_RFC           = 10,
  parameter int unsigned T_MRD           = 2,
  parameter int unsigned AR_COUNT        = 8,
  parameter int unsigned REFI_CYCLES     = 1300,
  parameter logic [2:0]  BURST_LENGTH    = 3'b000,
  parameter logic        ADDRESSING_MODE = 1'b0,
  parameter logic [2:0]  CAS_LATENCY     = 3'b010,
  parameter logic        WRITE_MODE      = 1'b1
`ifdef SDRAM_INIT_EMRS_EN
  ,
  parameter logic [ADDR_W-1:0] EMRS_VALUE = '0
`endif
) (
  input logic               clk_i,
  input logic               rst_i,
  sdram_init_ctrl_if.master bus
);
  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_PAUSE  = 4'd1;
  localparam logic [3:0] S_PRE    = 4'd2;
  localparam logic [3:0] S_PRE_W  = 4'd3;
  localparam logic [3:0] S_AR     = 4'd4;
  localparam logic [3:0] S_AR_W   = 4'd5;
  localparam logic [3:0] S_MRS    = 4'd6;
  localparam logic [3:0] S_MRS_W  = 4'd7;
  localparam logic [3:0] S_DONE   = 4'd8;
`ifdef SDRAM_INIT_EMRS_EN
  localparam logic [3:0] S_EMRS   = 4'd9;
  localparam logic [3:0] S_EMRS_W = 4'd10;
  localparam logic [3:0] S_POST_MRS = S_EMRS;
`else
  localparam logic [3:0] S_POST_MRS = S_DONE;
`endif

  localparam logic [3:0] CMD_DESELECT = 4'b1111;
  localparam logic [3:0] CMD_NOP      = 4'b0111;
  localparam logic [3:0] CMD_PRE      = 4'b0010;
  localparam logic [3:0] CMD_AREF     = 4'b0001;
  localparam logic [3:0] CMD_LMR      = 4'b0000;

  // Wait counter holds (interval - 1), so it is sized by the longest interval (at least 2).
  localparam int unsigned MAX_A  = (PAUSE_CYCLES > T_RP) ? PAUSE_CYCLES : T_RP;
  localparam int unsigned MAX_B  = (T_RFC > T_MRD) ? T_RFC : T_MRD;
  localparam int unsigned MAX_AB = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAX_IV = (MAX_AB > 2) ? MAX_AB : 2;
  localparam int unsigned CW     = $clog2(MAX_IV);
  localparam int unsigned ARW    = $clog2(AR_COUNT + 1);
  localparam int unsigned RW     = $clog2(REFI_CYCLES);

  localparam logic [CW-1:0]     LD_PAUSE    = CW'(PAUSE_CYCLES - 1);
  localparam logic [CW-1:0]     LD_RP       = CW'((T_RP > 1) ? T_RP - 2 : 0);
  localparam logic [CW-1:0]     LD_RFC      = CW'((T_RFC > 1) ? T_RFC - 2 : 0);
  localparam logic [CW-1:0]     LD_MRD      = CW'((T_MRD > 1) ? T_MRD - 2 : 0);
  localparam logic [ARW-1:0]    AR_TARGET   = ARW'(AR_COUNT);
  localparam logic [RW-1:0]     REFI_LOAD   = RW'(REFI_CYCLES - 1);
  // After an ack the ack cycle itself counts as the first clock of the next interval.
  localparam logic [RW-1:0]     REFI_RELOAD = RW'(REFI_CYCLES - 2);
  localparam logic [ADDR_W-1:0] A_ALLBANKS  = ADDR_W'(11'h400);
  localparam logic [ADDR_W-1:0] MR_VALUE    =
    ADDR_W'({WRITE_MODE, 2'b00, CAS_LATENCY, ADDRESSING_MODE, BURST_LENGTH});

  logic [3:0]        state_r, state_s;
  logic [CW-1:0]     cnt_r, ld_s;
  logic [ARW-1:0]    ar_cnt_r;
  logic [RW-1:0]     refi_r;
  logic              req_r;
  logic [3:0]        cmd_r, cmd_s;
  logic              cke_r, cke_s;
  logic [ADDR_W-1:0] a_r, a_s;
  logic [BA_W-1:0]   bs_r, bs_s;
  logic              done_r, done_s;
  logic              busy_r, busy_s;

  // Next-state decision for the init sequence.
  always_comb begin
    state_s = state_r;
    case (state_r)
      S_IDLE:   if (bus.run_i) state_s = S_PAUSE; else state_s = S_IDLE;
      S_PAUSE:  if (cnt_r == '0) state_s = S_PRE; else state_s = S_PAUSE;
      S_PRE:    if (T_RP > 1) state_s = S_PRE_W; else state_s = S_AR;
      S_PRE_W:  if (cnt_r == '0) state_s = S_AR; else state_s = S_PRE_W;
      S_AR: begin
        if (T_RFC > 1) state_s = S_AR_W;
        else if (ar_cnt_r < AR_TARGET) state_s = S_AR;
        else state_s = S_MRS;
      end
      S_AR_W: begin
        if (cnt_r != '0) state_s = S_AR_W;
        else if (ar_cnt_r < AR_TARGET) state_s = S_AR;
        else state_s = S_MRS;
      end
      S_MRS:    if (T_MRD > 1) state_s = S_MRS_W; else state_s = S_POST_MRS;
      S_MRS_W:  if (cnt_r == '0) state_s = S_POST_MRS; else state_s = S_MRS_W;
`ifdef SDRAM_INIT_EMRS_EN
      S_EMRS:   if (T_MRD > 1) state_s = S_EMRS_W; else state_s = S_DONE;
      S_EMRS_W: if (cnt_r == '0) state_s = S_DONE; else state_s = S_EMRS_W;
`endif
      S_DONE:   if (bus.run_i) state_s = S_PAUSE; else state_s = S_DONE;
      default:  state_s = S_IDLE;
    endcase
  end

  // Wait-counter reload value for the state being entered.
  always_comb begin
    case (state_s)
      S_PAUSE:  ld_s = LD_PAUSE;
      S_PRE_W:  ld_s = LD_RP;
      S_AR_W:   ld_s = LD_RFC;
      S_MRS_W:  ld_s = LD_MRD;
`ifdef SDRAM_INIT_EMRS_EN
      S_EMRS_W: ld_s = LD_MRD;
`endif
      default:  ld_s = '0;
    endcase
  end

  // Pin values for the upcoming state; registered below so outputs align with the state.
  always_comb begin
    cmd_s  = CMD_NOP;
    cke_s  = 1'b1;
    a_s    = '0;
    bs_s   = '0;
    done_s = 1'b0;
    busy_s = 1'b1;
    case (state_s)
      S_IDLE: begin cmd_s = CMD_DESELECT; cke_s = 1'b0; busy_s = 1'b0; end
      S_PRE:  begin cmd_s = CMD_PRE; a_s = A_ALLBANKS; end
      S_AR:   cmd_s = CMD_AREF;
      S_MRS:  begin cmd_s = CMD_LMR; a_s = MR_VALUE; end
`ifdef SDRAM_INIT_EMRS_EN
      S_EMRS: begin cmd_s = CMD_LMR; a_s = EMRS_VALUE; bs_s = BA_W'(2'b10); end
`endif
      S_DONE: begin cmd_s = CMD_DESELECT; done_s = 1'b1; busy_s = 1'b0; end
      default: cmd_s = CMD_NOP;
    endcase
  end

  // Sequencer state, counters, refresh timer and registered outputs.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_r  <= S_IDLE;
      cnt_r    <= '0;
      ar_cnt_r <= '0;
      refi_r   <= '0;
      req_r    <= 1'b0;
      cmd_r    <= CMD_DESELECT;
      cke_r    <= 1'b0;
      a_r      <= '0;
      bs_r     <= '0;
      done_r   <= 1'b0;
      busy_r   <= 1'b0;
    end else begin
      state_r <= state_s;
      cmd_r   <= cmd_s;
      cke_r   <= cke_s;
      a_r     <= a_s;
      bs_r    <= bs_s;
      done_r  <= done_s;
      busy_r  <= busy_s;

      if (state_s != state_r) cnt_r <= ld_s;
      else if (cnt_r != '0) cnt_r <= cnt_r - CW'(1'b1);
      else cnt_r <= cnt_r;

      if (state_s == S_PAUSE) ar_cnt_r <= '0;
      else if (state_s == S_AR) ar_cnt_r <= ar_cnt_r + ARW'(1'b1);
      else ar_cnt_r <= ar_cnt_r;

      // The timer is frozen while a request is outstanding so none is lost or doubled.
      if (state_s != S_DONE) begin
        req_r  <= 1'b0;
        refi_r <= '0;
      end else if (state_r != S_DONE) begin
        req_r  <= 1'b0;
        refi_r <= REFI_LOAD;
      end else if (req_r) begin
        if (bus.ref_ack_i) begin
          req_r  <= 1'b0;
          refi_r <= REFI_RELOAD;
        end else begin
          req_r  <= 1'b1;
          refi_r <= refi_r;
        end
      end else if (refi_r == '0) begin
        req_r  <= 1'b1;
        refi_r <= refi_r;
      end else begin
        req_r  <= 1'b0;
        refi_r <= refi_r - RW'(1'b1);
      end
    end
  end

  assign bus.cmd_o     = cmd_r;
  assign bus.cke_o     = cke_r;
  assign bus.a_o       = a_r;
  assign bus.bs_o      = bs_r;
  assign bus.done_o    = done_r;
  assign bus.busy_o    = busy_r;
  assign bus.ref_req_o = req_r;
endmodule

// File: tb/tb_sdram_init_ctrl.sv
// Directed bench for sdram_init_ctrl: table of per-cycle vectors plus hand-written
// refresh handshake, restart-from-DONE and mid-sequence reset sequences.
module tb_sdram_init_ctrl;
`ifdef SDRAM_INIT_EMRS_EN
  localparam int TD = 28;
`else
  localparam int TD = 26;
`endif
  localparam logic [11:0] EMRS_V = 12'h021;

  typedef struct packed {
    logic [3:0]  cmd;
    logic        cke;
    logic [11:0] a;
    logic [1:0]  bs;
    logic        done;
    logic        busy;
    logic        req;
  } outs_t;

  typedef struct {
    int    cyc;
    logic  run;
    logic  ack;
    outs_t exp;
    string name;
  } vec_t;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_init_ctrl_if #(.ADDR_W(12), .BA_W(2)) bus ();

  sdram_init_ctrl #(
    .ADDR_W(12), .BA_W(2), .PAUSE_CYCLES(10), .T_RP(3), .T_RFC(5), .T_MRD(2),
    .AR_COUNT(2), .REFI_CYCLES(20), .BURST_LENGTH(3'b000), .ADDRESSING_MODE(1'b0),
    .CAS_LATENCY(3'b010), .WRITE_MODE(1'b1)
`ifdef SDRAM_INIT_EMRS_EN
    , .EMRS_VALUE(EMRS_V)
`endif
  ) dut (
    .clk_i(clk),
    .rst_i(rst),
    .bus  (bus)
  );

  int   cyc;
  int   n_tests;
  int   n_fail;
  vec_t tbl[$];
  outs_t o_idle, o_nop, o_pre, o_ar, o_mrs, o_emrs, o_done, o_req;

  function automatic outs_t mk(logic [3:0] cmd, logic cke, logic [11:0] a, logic [1:0] bs,
                               logic done, logic busy, logic req);
    outs_t o;
    o.cmd = cmd; o.cke = cke; o.a = a; o.bs = bs; o.done = done; o.busy = busy; o.req = req;
    return o;
  endfunction

  task automatic add(input int c, input logic run, input logic ack, input outs_t e, input string n);
    vec_t v;
    v.cyc = c; v.run = run; v.ack = ack; v.exp = e; v.name = n;
    tbl.push_back(v);
  endtask

  // Advance to cycle c; one-cycle input pulses are dropped after each edge.
  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
      cyc++;
      bus.run_i     = 1'b0;
      bus.ref_ack_i = 1'b0;
      rst           = 1'b0;
    end
  endtask

  task automatic check(input string name, input outs_t exp);
    outs_t got;
    @(negedge clk);
    got.cmd = bus.cmd_o; got.cke = bus.cke_o; got.a = bus.a_o; got.bs = bus.bs_o;
    got.done = bus.done_o; got.busy = bus.busy_o; got.req = bus.ref_req_o;
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s cyc=%0d got cmd=%h cke=%b a=%h bs=%b done=%b busy=%b req=%b, expected cmd=%h cke=%b a=%h bs=%b done=%b busy=%b req=%b",
               name, cyc, got.cmd, got.cke, got.a, got.bs, got.done, got.busy, got.req,
               exp.cmd, exp.cke, exp.a, exp.bs, exp.done, exp.busy, exp.req);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d time limit reached", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int r;
    int s;
    bus.run_i = 1'b0; bus.ref_ack_i = 1'b0; rst = 1'b1;
    cyc = 0; n_tests = 0; n_fail = 0;

    o_idle = mk(4'hF, 1'b0, 12'h000, 2'b00, 1'b0, 1'b0, 1'b0);
    o_nop  = mk(4'h7, 1'b1, 12'h000, 2'b00, 1'b0, 1'b1, 1'b0);
    o_pre  = mk(4'h2, 1'b1, 12'h400, 2'b00, 1'b0, 1'b1, 1'b0);
    o_ar   = mk(4'h1, 1'b1, 12'h000, 2'b00, 1'b0, 1'b1, 1'b0);
    o_mrs  = mk(4'h0, 1'b1, 12'h220, 2'b00, 1'b0, 1'b1, 1'b0);
    o_emrs = mk(4'h0, 1'b1, EMRS_V,  2'b10, 1'b0, 1'b1, 1'b0);
    o_done = mk(4'hF, 1'b1, 12'h000, 2'b00, 1'b1, 1'b0, 1'b0);
    o_req  = mk(4'hF, 1'b1, 12'h000, 2'b00, 1'b1, 1'b0, 1'b1);

    add(0,  1'b1, 1'b0, o_idle, "reset_idle");
    add(1,  1'b0, 1'b0, o_nop,  "pause_start");
    add(3,  1'b0, 1'b1, o_nop,  "ack_in_pause");
    add(5,  1'b1, 1'b0, o_nop,  "run_in_pause");
    add(10, 1'b0, 1'b0, o_nop,  "pause_end");
    add(11, 1'b0, 1'b0, o_pre,  "precharge");
    add(12, 1'b0, 1'b0, o_nop,  "pre_wait_a");
    add(13, 1'b0, 1'b0, o_nop,  "pre_wait_b");
    add(14, 1'b0, 1'b0, o_ar,   "auto_refresh_0");
    add(15, 1'b0, 1'b0, o_nop,  "ar_wait");
    add(19, 1'b0, 1'b0, o_ar,   "auto_refresh_1");
    add(23, 1'b0, 1'b0, o_nop,  "ar_wait_end");
    add(24, 1'b0, 1'b0, o_mrs,  "load_mode");
    add(25, 1'b0, 1'b0, o_nop,  "mrs_wait");
`ifdef SDRAM_INIT_EMRS_EN
    add(26, 1'b0, 1'b0, o_emrs, "emrs");
    add(27, 1'b0, 1'b0, o_nop,  "emrs_wait");
`endif
    add(TD,      1'b0, 1'b0, o_done, "done");
    add(TD + 1,  1'b0, 1'b0, o_done, "done_hold");
    add(TD + 5,  1'b0, 1'b1, o_done, "ack_no_request");
    add(TD + 19, 1'b0, 1'b0, o_done, "refi_not_yet");
    add(TD + 20, 1'b0, 1'b0, o_req,  "ref_req_rise");

    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    foreach (tbl[i]) begin
      goto(tbl[i].cyc);
      bus.run_i     = tbl[i].run;
      bus.ref_ack_i = tbl[i].ack;
      check(tbl[i].name, tbl[i].exp);
    end

    // Request held with ack withheld, then acknowledged.
    for (int c = TD + 21; c <= TD + 29; c++) begin
      goto(c);
      check("req_hold", o_req);
    end
    goto(TD + 30); bus.ref_ack_i = 1'b1; check("req_at_ack", o_req);
    goto(TD + 31); check("req_cleared", o_done);
    goto(TD + 49); check("refi_again_not_yet", o_done);
    goto(TD + 50); check("ref_req_again", o_req);

    // Restart from DONE with a request pending.
    r = TD + 50;
    bus.run_i = 1'b1;
    goto(r + 1);  check("restart_clears", o_nop);
    goto(r + 4);  bus.ref_ack_i = 1'b1; check("ack_during_restart", o_nop);
    goto(r + 6);  bus.run_i = 1'b1; check("run_ignored", o_nop);
    goto(r + 10); check("restart_pause_end", o_nop);
    goto(r + 11); check("restart_precharge", o_pre);
    goto(r + 14); check("restart_ar0", o_ar);

    // Reset mid-sequence, then a full replay.
    goto(r + 15); rst = 1'b1; check("before_reset", o_nop);
    goto(r + 16); check("mid_reset_idle", o_idle);
    goto(r + 19); check("idle_stays", o_idle);
    s = r + 20;
    goto(s);      bus.run_i = 1'b1; check("rerun_idle", o_idle);
    goto(s + 1);  check("rerun_pause", o_nop);
    goto(s + 11); check("rerun_precharge", o_pre);
    goto(s + 14); check("rerun_ar0", o_ar);
    goto(s + 19); check("rerun_ar1", o_ar);
    goto(s + 24); check("rerun_load_mode", o_mrs);
    goto(s + TD - 1); check("rerun_last_wait", o_nop);
    goto(s + TD); check("rerun_done", o_done);
    goto(s + TD + 19); check("rerun_refi_not_yet", o_done);
    goto(s + TD + 20); check("rerun_ref_req", o_req);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
